// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
//   Request/response bundle between the ALU issue logic (master) and the
//   multi-cycle shift sequencer (slave).
//   Optional feature macro: SHIFT_WORD_OPS_EN (adds the 'word' signal for RV64 *W ops).
//   Signals:
//     in_valid / in_ready    request handshake
//     op[1:0]                00 SLL, 01 SRL, 10 SRA, 11 pass-through
//     word                   32-bit *W variant (only with SHIFT_WORD_OPS_EN)
//     a[63:0], b[63:0]       operand and shift amount
//     kill                   abort of the in-flight request
//     out_valid / out_ready  result handshake
//     s[63:0]                registered result
//     busy                   sequencer is not idle
interface shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
`ifdef SHIFT_WORD_OPS_EN
    logic        word;
`endif
    logic [63:0] a;
    logic [63:0] b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s;
    logic        busy;

`ifdef SHIFT_WORD_OPS_EN
    modport master (output in_valid, op, word, a, b, kill, out_ready,
                    input  in_ready, out_valid, s, busy);
    modport slave  (input  in_valid, op, word, a, b, kill, out_ready,
                    output in_ready, out_valid, s, busy);
`else
    modport master (output in_valid, op, a, b, kill, out_ready,
                    input  in_ready, out_valid, s, busy);
    modport slave  (input  in_valid, op, a, b, kill, out_ready,
                    output in_ready, out_valid, s, busy);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle controller for the RV64 integer shifter. One request
//   (SLL/SRL/SRA) is accepted, shifted by at most STEP positions per cycle
//   and the 64-bit result is returned over a second valid/ready handshake.
//   Optional feature macro: SHIFT_WORD_OPS_EN (RV64 *W variants, 32-bit
//   operand with sign-extended result, amount taken from b[4:0]).
//   Parameters:
//     STEP   max bit positions per cycle, power of 2 in 1..64
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    shift_sequencer_if.slave (request, result, kill, busy)
module shift_sequencer #(
    parameter int STEP = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [6:0] STEP_W = 7'(STEP);

    state_t      state;
    logic [63:0] acc;
    logic [6:0]  rem;
    logic [1:0]  op_q;
    logic        word_q;
    logic [63:0] s_q;

    logic        word_in;
    logic [5:0]  amount;
    logic [63:0] acc_init;
    logic [6:0]  k;
    logic [63:0] acc_next;

    // Upper shift-amount bits are architecturally ignored.
    logic        unused_b;
    assign unused_b = ^bus.b[63:6];

`ifdef SHIFT_WORD_OPS_EN
    assign word_in = bus.word;
`else
    assign word_in = 1'b0;
`endif

    // Word results are the low 32 bits of the accumulator, sign-extended.
    function automatic logic [63:0] fmt(input logic [63:0] r, input logic w);
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    // Accept-time operand preparation. For *W ops the upper half is
    // pre-filled so that a full 64-bit shift yields the right low word.
    always_comb begin
        amount   = bus.b[5:0];
        acc_init = bus.a;
        if (word_in) begin
            amount   = {1'b0, bus.b[4:0]};
            acc_init = (bus.op == 2'b10) ? {{32{bus.a[31]}}, bus.a[31:0]}
                                         : {32'b0, bus.a[31:0]};
        end
    end

    // One narrow shift step of k = min(rem, STEP) positions.
    always_comb begin
        k = (rem < STEP_W) ? rem : STEP_W;
        case (op_q)
            2'b00:   acc_next = acc << k;
            2'b01:   acc_next = acc >> k;
            2'b10:   acc_next = $signed(acc) >>> k;
            default: acc_next = acc;
        endcase
    end

    assign bus.in_ready  = (state == IDLE) && !bus.kill;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.s         = s_q;

    // Main sequencer: accept, step the accumulator, hold the result.
    // kill wins over out_ready in DONE; s is left untouched by kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
            s_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        acc    <= acc_init;
                        rem    <= {1'b0, amount};
                        op_q   <= bus.op;
                        word_q <= word_in;
                        if (bus.op == 2'b11) begin
                            state <= DONE;
                            s_q   <= bus.a;
                        end else if (amount == 6'd0) begin
                            state <= DONE;
                            s_q   <= fmt(acc_init, word_in);
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.kill) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        rem <= rem - k;
                        if (rem <= STEP_W) begin
                            state <= DONE;
                            s_q   <= fmt(acc_next, word_q);
                        end
                    end
                end
                DONE: begin
                    if (bus.kill || bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Directed bench for shift_sequencer (STEP=8) with hand-computed results.
//   Word-op vectors are included when SHIFT_WORD_OPS_EN is defined.
module tb_shift_sequencer;

    localparam int STEP = 8;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    shift_sequencer_if bus ();

    shift_sequencer #(.STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after the accept edge, then
    // count clock edges until out_valid (bounded).
    task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic w, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
`ifdef SHIFT_WORD_OPS_EN
        bus.word     = w;
`else
        if (w) $display("[TB] word request issued in a 64-bit build");
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = '1;
        bus.b        = 64'd17;
        bus.op       = 2'b11;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("done_seen", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic releaseResult();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("release_idle", 64'(bus.busy), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] s;
    } vec_t;

    vec_t vecs[8];
    int   lat;
    logic seen;

    initial begin
        assertCount = 0;
        failCount   = 0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SHIFT_WORD_OPS_EN
        bus.word      = 1'b0;
`endif
        rst_n = 1'b0;

        #3;
        checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_busy",      64'(bus.busy),      64'd0);
        checkOutput("rst_s",         bus.s,              64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] SLL a=1 sweep of all amounts");
        for (int i = 0; i < 64; i++) begin
            applyStimulus(2'b00, 64'd1, 64'(i), 1'b0, lat);
            checkOutput($sformatf("sll_s_%0d", i), bus.s, 64'd1 << i);
            if (i == 0)
                checkOutput("sll_lat_0", 64'(lat <= 1), 64'd1);
            else
                checkOutput($sformatf("sll_lat_%0d", i), 64'(lat), 64'((i + STEP - 1) / STEP));
            releaseResult();
        end

        $display("[TB] directed vectors");
        vecs[0] = '{2'b10, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{2'b01, 64'h8000_0000_0000_0000, 64'd63, 64'h0000_0000_0000_0001};
        vecs[2] = '{2'b00, 64'd3, 64'hFFFF_FFFF_FFFF_FFC4, 64'd48};
        vecs[3] = '{2'b01, 64'hF000_0000_0000_0000, 64'd4, 64'h0F00_0000_0000_0000};
        vecs[4] = '{2'b10, 64'hF000_0000_0000_0000, 64'd4, 64'hFF00_0000_0000_0000};
        vecs[5] = '{2'b10, 64'h7000_0000_0000_0000, 64'd60, 64'h0000_0000_0000_0007};
        vecs[6] = '{2'b11, 64'hDEAD_BEEF_0123_4567, 64'd9, 64'hDEAD_BEEF_0123_4567};
        vecs[7] = '{2'b00, 64'h0000_0000_0000_00FF, 64'd56, 64'hFF00_0000_0000_0000};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
            checkOutput($sformatf("vec_%0d", i), bus.s, vecs[i].s);
            releaseResult();
        end

        $display("[TB] result stall");
        applyStimulus(2'b00, 64'd1, 64'd40, 1'b0, lat);
        checkOutput("stall_lat", 64'(lat), 64'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_s",        bus.s,              64'd1 << 40);
            checkOutput("stall_valid",    64'(bus.out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("stall_idle_busy",  64'(bus.busy),      64'd0);
        checkOutput("stall_idle_ready", 64'(bus.in_ready),  64'd1);
        checkOutput("stall_idle_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] kill during SHIFT");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.a        = 64'd1;
        bus.b        = 64'd63;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("kill_busy_pre", 64'(bus.busy), 64'd1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        checkOutput("kill_busy",  64'(bus.busy),      64'd0);
        checkOutput("kill_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("kill_s",     bus.s,              64'd1 << 40);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checkOutput("kill_no_valid", 64'(seen), 64'd0);

        $display("[TB] kill in IDLE blocks acceptance");
        @(negedge clk);
        bus.kill     = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.a        = 64'd5;
        bus.b        = 64'd3;
        #1;
        checkOutput("idle_kill_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        checkOutput("idle_kill_busy", 64'(bus.busy), 64'd0);

        $display("[TB] reset mid-SHIFT");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b10;
        bus.a        = 64'h8000_0000_0000_0000;
        bus.b        = 64'd63;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_s",     bus.s,              64'd0);
        checkOutput("mid_rst_busy",  64'(bus.busy),      64'd0);
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b01, 64'h0000_0000_0000_0100, 64'd8, 1'b0, lat);
        checkOutput("post_rst_s",   bus.s,     64'd1);
        checkOutput("post_rst_lat", 64'(lat), 64'd1);
        releaseResult();

`ifdef SHIFT_WORD_OPS_EN
        $display("[TB] word ops");
        applyStimulus(2'b00, 64'd1, 64'd31, 1'b1, lat);
        checkOutput("w_sll31", bus.s, 64'hFFFF_FFFF_8000_0000);
        releaseResult();
        applyStimulus(2'b01, 64'h0000_0000_8000_0000, 64'd0, 1'b1, lat);
        checkOutput("w_srl0", bus.s, 64'hFFFF_FFFF_8000_0000);
        releaseResult();
        applyStimulus(2'b00, 64'd1, 64'd33, 1'b1, lat);
        checkOutput("w_sll_b5_ignored", bus.s, 64'd2);
        releaseResult();
        applyStimulus(2'b10, 64'h1234_5678_8000_0000, 64'd4, 1'b1, lat);
        checkOutput("w_sra4", bus.s, 64'hFFFF_FFFF_F800_0000);
        releaseResult();
        applyStimulus(2'b01, 64'hFFFF_FFFF_8000_0000, 64'd4, 1'b1, lat);
        checkOutput("w_srl4", bus.s, 64'h0000_0000_0800_0000);
        releaseResult();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
